mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/cpu_types_pkg.sv | 14 +
 rtl/mem_arbiter.sv | 106 ++++++++++
 tb/tb_mem_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word and RAM status.
// Imported by the memory-side blocks.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one RAM port between instruction and data sides.
// Data wins ties, bounded by MAX_DSTREAK while an instruction waits.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int MAX_DSTREAK = 2
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate
);

  localparam int SW = $clog2(MAX_DSTREAK + 1);
  localparam logic [SW-1:0] SMAX = SW'(MAX_DSTREAK);

  typedef enum logic [1:0] {
    IDLE,
    IGRANT,
    DGRANT
  } state_t;

  state_t        state, next_state;
  logic [SW-1:0] streak, next_streak;
  logic          dpend;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      streak <= '0;
    end else begin
      state  <= next_state;
      streak <= next_streak;
    end
  end

  always_comb begin
    dpend       = dREN | dWEN;
    next_state  = state;
    next_streak = streak;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    iwait       = iREN;
    dwait       = dpend;
    iload       = ramload;
    dload       = ramload;
    unique case (state)
      IDLE: begin
        if (dpend && (!iREN || streak < SMAX))
          next_state = DGRANT;
        else if (iREN)
          next_state = IGRANT;
      end
      IGRANT: begin
        ramaddr = iaddr;
        ramREN  = 1'b1;
        if (!iREN) begin
          next_state = IDLE;
        end else if (ramstate == ACCESS) begin
          iwait       = 1'b0;
          next_state  = IDLE;
          next_streak = '0;
        end else if (ramstate == ERROR) begin
          next_state = IDLE;
        end
      end
      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if (!dpend) begin
          next_state = IDLE;
        end else if (ramstate == ACCESS) begin
          dwait      = 1'b0;
          next_state = IDLE;
          // streak only matters while an instruction is waiting
          if (!iREN)
            next_streak = '0;
          else if (streak != SMAX)
            next_streak = streak + SW'(1);
        end else if (ramstate == ERROR) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios, then random
// traffic checked by a scoreboard against a memory model.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int MAXD = 2;

  logic      CLK, nRST;
  logic      iREN, dREN, dWEN;
  word_t     iaddr, daddr, dstore;
  logic      iwait, dwait;
  word_t     iload, dload;
  logic      ramREN, ramWEN;
  word_t     ramaddr, ramstore, ramload;
  ramstate_t ramstate;

  mem_arbiter #(.MAX_DSTREAK(MAXD)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  typedef struct {
    bit    wr;
    word_t addr;
    word_t data;
  } exp_t;

  int        checks = 0;
  int        failures = 0;
  word_t     ram_mem [word_t];
  word_t     ref_dmem [word_t];
  ramstate_t script [$];
  exp_t      iq [$];
  exp_t      dq [$];
  bit        mon_en = 0;

  initial CLK = 0;
  always #5 CLK = ~CLK;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic word_t ifn(word_t a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic word_t rd(word_t a);
    return ram_mem.exists(a) ? ram_mem[a] : '0;
  endfunction

  // RAM model: answers each strobed cycle from script or at random
  initial begin
    ramstate = FREE;
    ramload  = '0;
    forever begin
      @(posedge CLK);
      #2;
      if (ramREN | ramWEN) begin
        if (script.size() > 0) begin
          ramstate = script.pop_front();
        end else begin
          int r;
          r = $urandom_range(0, 99);
          ramstate = (r < 50) ? ACCESS :
                     (r < 85) ? BUSY : ERROR;
        end
        ramload = rd(ramaddr);
      end else begin
        ramstate = FREE;
        ramload  = '0;
      end
    end
  end

  initial forever begin
    @(negedge CLK);
    if (ramWEN && ramstate == ACCESS)
      ram_mem[ramaddr] = ramstore;
  end

  // Scoreboard monitor
  bit prev_iren = 0;
  bit prev_done = 0;
  int wcnt = 0;
  always @(negedge CLK) begin
    if (mon_en) begin
      bit ic, dc;
      exp_t e;
      ic = iREN && !iwait;
      dc = (dREN | dWEN) && !dwait;
      if (prev_done)
        chk("idle_after", {30'd0, ramREN, ramWEN}, 0);
      if (iREN && !prev_iren) wcnt = 0;
      if (ic) begin
        if (iq.size() == 0) begin
          chk("i_unexpected", 1, 0);
        end else begin
          e = iq.pop_front();
          chk("i_addr", ramaddr, e.addr);
          chk("i_load", iload, e.data);
        end
        wcnt = 0;
      end
      if (dc) begin
        if (dq.size() == 0) begin
          chk("d_unexpected", 1, 0);
        end else begin
          e = dq.pop_front();
          chk("d_addr", ramaddr, e.addr);
          if (e.wr) begin
            chk("d_wen", {30'd0, ramWEN, ramREN}, 2);
            chk("d_store", ramstore, e.data);
          end else begin
            chk("d_ren", {30'd0, ramWEN, ramREN}, 1);
            chk("d_load", dload, e.data);
          end
        end
        if (iREN) begin
          wcnt++;
          chk("starve", 32'(wcnt <= MAXD), 1);
        end
      end
      prev_done = ic | dc;
      prev_iren = iREN;
    end
  end

  task automatic run_i(int n);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      int t;
      e.wr   = 0;
      e.addr = word_t'($urandom_range(0, 63)) << 2;
      e.data = ifn(e.addr);
      iq.push_back(e);
      iaddr = e.addr;
      iREN  = 1;
      t = 0;
      do begin
        @(negedge CLK);
        t++;
      end while (iwait && t < 300);
      chk("i_timeout", {31'd0, iwait}, 0);
      @(posedge CLK); #1;
      iREN  = 0;
      iaddr = $urandom;
      repeat ($urandom_range(0, 3)) begin
        @(posedge CLK); #1;
      end
    end
  endtask

  task automatic run_d(int n);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      int t, kind;
      kind   = $urandom_range(0, 2);
      e.wr   = (kind != 0);
      e.addr = 32'h100 + (word_t'($urandom_range(0, 15)) << 2);
      if (e.wr) begin
        e.data = $urandom;
        ref_dmem[e.addr] = e.data;
      end else begin
        e.data = ref_dmem.exists(e.addr) ? ref_dmem[e.addr] : '0;
      end
      dq.push_back(e);
      daddr  = e.addr;
      dstore = e.wr ? e.data : $urandom;
      dREN   = (kind != 1);
      dWEN   = (kind != 0);
      t = 0;
      do begin
        @(negedge CLK);
        t++;
      end while (dwait && t < 300);
      chk("d_timeout", {31'd0, dwait}, 0);
      @(posedge CLK); #1;
      dREN = 0;
      dWEN = 0;
      repeat ($urandom_range(0, 3)) begin
        @(posedge CLK); #1;
      end
    end
  endtask

  task automatic count_streak(output int nd, output bit gi);
    nd = 0;
    gi = 0;
    for (int k = 0; k < 40 && !gi; k++) begin
      @(negedge CLK);
      if ((dREN | dWEN) && !dwait) nd++;
      if (iREN && !iwait) gi = 1;
    end
  endtask

  task automatic fill(ramstate_t s, int n);
    script.delete();
    repeat (n) script.push_back(s);
  endtask

  task automatic drop_all();
    @(posedge CLK); #1;
    iREN = 0;
    dREN = 0;
    dWEN = 0;
    @(posedge CLK); #1;
  endtask

  initial begin
    int  nd, hi;
    bit  gi;
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  nd, hi;
    bit  gi;
    nRST = 0;
    iREN = 0; dREN = 0; dWEN = 0;
    iaddr = '0; daddr = '0; dstore = '0;
    repeat (2) @(negedge CLK);
    chk("rst_strobe", {30'd0, ramREN, ramWEN}, 0);
    chk("rst_addr", ramaddr, 0);
    chk("rst_store", ramstore, 0);
    chk("rst_wait", {30'd0, iwait, dwait}, 0);
    nRST = 1;

    // lone instruction read, minimum latency
    ram_mem[32'h40] = 32'h8C010004;
    fill(ACCESS, 1);
    @(posedge CLK); #1;
    iREN = 1; iaddr = 32'h40;
    @(negedge CLK);
    chk("t1_c1_iwait", {31'd0, iwait}, 1);
    chk("t1_c1_ren", {31'd0, ramREN}, 0);
    @(negedge CLK);
    chk("t1_c2_ren", {31'd0, ramREN}, 1);
    chk("t1_c2_addr", ramaddr, 32'h40);
    chk("t1_c2_iwait", {31'd0, iwait}, 0);
    chk("t1_c2_iload", iload, 32'h8C010004);
    @(posedge CLK); #1;
    iREN = 0;
    @(negedge CLK);
    chk("t1_c3_idle", {30'd0, ramREN, ramWEN}, 0);
    @(posedge CLK); #1;

    // instruction and data write together: data first
    fill(ACCESS, 2);
    iREN = 1; iaddr = 32'h44;
    dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF;
    @(negedge CLK);
    @(negedge CLK);
    chk("t2_wen", {30'd0, ramWEN, ramREN}, 2);
    chk("t2_addr", ramaddr, 32'h100);
    chk("t2_store", ramstore, 32'hDEADBEEF);
    chk("t2_dwait", {30'd0, dwait, iwait}, 1);
    @(posedge CLK); #1;
    dWEN = 0;
    @(negedge CLK);
    chk("t2_idle", {30'd0, ramREN, ramWEN}, 0);
    @(negedge CLK);
    chk("t2_igrant", {30'd0, ramREN, iwait}, 2);
    chk("t2_iaddr", ramaddr, 32'h44);
    chk("t2_mem", rd(32'h100), 32'hDEADBEEF);
    drop_all();

    // streak bound, twice to show it clears
    for (int r = 0; r < 2; r++) begin
      fill(ACCESS, 8);
      iREN = 1; iaddr = 32'h48;
      dREN = 1; daddr = 32'h104;
      count_streak(nd, gi);
      chk("t3_dcount", nd, MAXD);
      chk("t3_icomp", {31'd0, gi}, 1);
      drop_all();
    end

    // BUSY x3 then ACCESS
    script.delete();
    repeat (3) script.push_back(BUSY);
    script.push_back(ACCESS);
    dREN = 1; daddr = 32'h108;
    hi = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (!dwait) break;
      hi++;
    end
    chk("t4_high", hi, 4);
    @(negedge CLK);
    chk("t4_idle", {30'd0, ramREN, dwait}, 1);
    drop_all();

    // ERROR then retry
    ram_mem[32'h10C] = 32'h12345678;
    script.delete();
    script.push_back(ERROR);
    script.push_back(ACCESS);
    dREN = 1; daddr = 32'h10C;
    @(negedge CLK);
    @(negedge CLK);
    chk("t5_err", {30'd0, ramREN, dwait}, 3);
    @(negedge CLK);
    chk("t5_idle", {30'd0, ramREN, dwait}, 1);
    @(negedge CLK);
    chk("t5_retry", {30'd0, ramREN, dwait}, 2);
    chk("t5_load", dload, 32'h12345678);
    drop_all();

    // reset mid-DGRANT with streak at 1
    script.delete();
    script.push_back(ACCESS);
    repeat (10) script.push_back(BUSY);
    iREN = 1; iaddr = 32'h50;
    dWEN = 1; daddr = 32'h110; dstore = 32'hCAFEF00D;
    repeat (4) @(negedge CLK);
    chk("t6_pre", {30'd0, ramWEN, ramREN}, 2);
    #2 nRST = 0;
    #1;
    chk("t6_strobe", {30'd0, ramWEN, ramREN}, 0);
    chk("t6_addr", ramaddr, 0);
    chk("t6_store", ramstore, 0);
    fill(ACCESS, 8);
    @(negedge CLK);
    nRST = 1;
    count_streak(nd, gi);
    chk("t6_dcount", nd, MAXD);
    chk("t6_icomp", {31'd0, gi}, 1);
    drop_all();

    // random traffic
    script.delete();
    ram_mem.delete();
    for (int a = 0; a < 64; a++)
      ram_mem[word_t'(a) << 2] = ifn(word_t'(a) << 2);
    mon_en = 1;
    fork
      run_i(40);
      run_d(60);
    join
    repeat (3) @(negedge CLK);
    mon_en = 0;
    chk("iq_empty", iq.size(), 0);
    chk("dq_empty", dq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
